sw_clk_btn_ctrl: RTL

Control unit for the stopwatch/clock design. It sits between the three button debouncers and the stopwatch and clock datapaths.
- Consumes single-cycle debounced pulses plus one debounced level.
- Sequences mode selection, stopwatch run/stop/clear, and clock time-set (hour/minute field select, increment with hold-to-repeat, inactivity timeout).
- All outputs are registered.

---
 rtl/sw_clk_pkg.sv | 15 +
 rtl/sw_clk_btn_ctrl_tick_gen.sv | 37 +++
 rtl/sw_clk_btn_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/sw_clk_pkg.sv
// Shared state and field encodings for the stopwatch/clock button controller.
package sw_clk_pkg;

  typedef enum logic [1:0] {
    ST_SW       = 2'd0,
    ST_CLK      = 2'd1,
    ST_SET_HOUR = 2'd2,
    ST_SET_MIN  = 2'd3
  } state_e;

  localparam logic [1:0] FLD_NONE = 2'd0;
  localparam logic [1:0] FLD_HOUR = 2'd1;
  localparam logic [1:0] FLD_MIN  = 2'd2;

endpackage

// File: rtl/sw_clk_btn_ctrl_tick_gen.sv
// Free-running prescaler: tick is high for one clk cycle at terminal count.
module tick_gen #(
  parameter int unsigned DIV = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count with wrap at terminal count
  always_comb begin
    if (cnt_q == TERM) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + ONE;
    end
  end

  // Prescaler register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == TERM);

endmodule

// File: rtl/sw_clk_btn_ctrl.sv
// Button control FSM: mode select, stopwatch run/clear, clock time-set with
// hold-to-repeat increment and inactivity timeout. All outputs registered.
module sw_clk_btn_ctrl
  import sw_clk_pkg::*;
#(
  parameter int unsigned F_TICK_DIV    = 1_000_000,
  parameter int unsigned HOLD_TICKS    = 50,
  parameter int unsigned REPEAT_TICKS  = 10,
  parameter int unsigned TIMEOUT_TICKS = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_run_p,
  input  logic       i_run_lvl,
  input  logic       i_clear_p,
  input  logic       i_mode_p,
  output logic       o_mode,
  output logic       o_sw_run,
  output logic       o_sw_clear,
  output logic       o_clk_set,
  output logic [1:0] o_set_field,
  output logic       o_inc_p,
  output logic [1:0] o_state
);

  localparam int unsigned HW = $clog2(HOLD_TICKS + 1);
  localparam int unsigned RW = $clog2(REPEAT_TICKS + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);

  logic tick;

  tick_gen #(.DIV(F_TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  state_e        state_q, state_d;
  logic          sw_run_q, sw_run_d;
  logic          sw_clear_q, sw_clear_d;
  logic          inc_q, inc_d;
  logic          mode_q, mode_d;
  logic          clk_set_q, clk_set_d;
  logic [1:0]    field_q, field_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [RW-1:0] rep_q, rep_d;
  logic [TW-1:0] to_q, to_d;
  logic          in_set, any_p, rep_evt, timeout;

  // Next-state, counters and registered-output decode
  always_comb begin
    state_d    = state_q;
    sw_run_d   = sw_run_q;
    sw_clear_d = 1'b0;
    inc_d      = 1'b0;
    hold_d     = hold_q;
    rep_d      = rep_q;
    to_d       = to_q;
    rep_evt    = 1'b0;
    timeout    = 1'b0;
    in_set     = (state_q == ST_SET_HOUR) || (state_q == ST_SET_MIN);
    any_p      = i_run_p | i_clear_p | i_mode_p;

    // hold_q saturates at HOLD_TICKS; rep_q then paces the repeat strobes
    if (in_set && i_run_lvl) begin
      if (tick) begin
        if (hold_q < HW'(HOLD_TICKS)) begin
          hold_d = hold_q + HW'(1);
          if (hold_q == HW'(HOLD_TICKS - 1)) begin
            rep_evt = 1'b1;
            rep_d   = '0;
          end else begin
            rep_d = rep_q;
          end
        end else if (rep_q == RW'(REPEAT_TICKS - 1)) begin
          rep_evt = 1'b1;
          rep_d   = '0;
        end else begin
          rep_d = rep_q + RW'(1);
        end
      end else begin
        hold_d = hold_q;
      end
    end else begin
      hold_d = '0;
      rep_d  = '0;
    end

    if (in_set && !any_p && !i_run_lvl) begin
      if (tick) begin
        if (to_q == TW'(TIMEOUT_TICKS - 1)) begin
          timeout = 1'b1;
          to_d    = '0;
        end else begin
          to_d = to_q + TW'(1);
        end
      end else begin
        to_d = to_q;
      end
    end else begin
      to_d = '0;
    end

    case (state_q)
      ST_SW: begin
        if (i_mode_p) begin
          state_d = ST_CLK;
        end else if (i_clear_p) begin
          sw_clear_d = ~sw_run_q;
        end else if (i_run_p) begin
          sw_run_d = ~sw_run_q;
        end else begin
          state_d = ST_SW;
        end
      end
      ST_CLK: begin
        if (i_mode_p) begin
          state_d = ST_SW;
        end else if (i_clear_p) begin
          state_d = ST_SET_HOUR;
        end else begin
          state_d = ST_CLK;
        end
      end
      ST_SET_HOUR, ST_SET_MIN: begin
        if (i_mode_p) begin
          state_d = ST_SW;
        end else if (i_clear_p) begin
          state_d = (state_q == ST_SET_HOUR) ? ST_SET_MIN : ST_CLK;
        end else if (i_run_p || rep_evt) begin
          inc_d = 1'b1;
        end else if (timeout) begin
          state_d = ST_CLK;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_SW;
      end
    endcase

    if (state_d != state_q) begin
      hold_d = '0;
      rep_d  = '0;
      to_d   = '0;
    end else begin
      to_d = to_d;
    end

    mode_d    = (state_d != ST_SW);
    clk_set_d = (state_d == ST_SET_HOUR) || (state_d == ST_SET_MIN);
    case (state_d)
      ST_SET_HOUR: field_d = FLD_HOUR;
      ST_SET_MIN:  field_d = FLD_MIN;
      default:     field_d = FLD_NONE;
    endcase
  end

  // State, counters and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_SW;
      sw_run_q   <= 1'b0;
      sw_clear_q <= 1'b0;
      inc_q      <= 1'b0;
      mode_q     <= 1'b0;
      clk_set_q  <= 1'b0;
      field_q    <= FLD_NONE;
      hold_q     <= '0;
      rep_q      <= '0;
      to_q       <= '0;
    end else begin
      state_q    <= state_d;
      sw_run_q   <= sw_run_d;
      sw_clear_q <= sw_clear_d;
      inc_q      <= inc_d;
      mode_q     <= mode_d;
      clk_set_q  <= clk_set_d;
      field_q    <= field_d;
      hold_q     <= hold_d;
      rep_q      <= rep_d;
      to_q       <= to_d;
    end
  end

  assign o_mode      = mode_q;
  assign o_sw_run    = sw_run_q;
  assign o_sw_clear  = sw_clear_q;
  assign o_clk_set   = clk_set_q;
  assign o_set_field = field_q;
  assign o_inc_p     = inc_q;
  assign o_state     = state_q;

endmodule
